anton_neopixel_stream: RTL and testbench

ANTON_NEOPIXEL_STREAM -- requirements
Module: anton_neopixel_stream

---
 rtl/anton_neopixel_stream.sv | 164 ++++++++++++++++
 tb/tb_anton_neopixel_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_stream.sv
// WS2812-style LED chain driver: 24-bit pixel buffer streamed MSB first,
// followed by a low latch gap; optional continuous looping.
module anton_neopixel_stream #(
    parameter int PIXELS       = 8,
    parameter int ADDR_W       = 3,
    parameter int CYCLES_BIT   = 12,
    parameter int CYCLES_T0H   = 3,
    parameter int CYCLES_T1H   = 8,
    parameter int CYCLES_RESET = 500
) (
    input  logic              CLK_10MHZ,
    input  logic              RESET_N,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [23:0]       WR_DATA,
    input  logic              START,
    input  logic              LOOP,
    output logic              BUSY,
    output logic              DONE,
    output logic              NEO_DATA,
    output logic [1:0]        STATE
);

    localparam int TICK_W = $clog2(CYCLES_BIT);
    localparam int GAP_W  = (CYCLES_RESET > 1) ? $clog2(CYCLES_RESET) : 1;
    localparam int IDX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_BIT - 1);
    localparam logic [TICK_W-1:0] T0H       = TICK_W'(CYCLES_T0H);
    localparam logic [TICK_W-1:0] T1H       = TICK_W'(CYCLES_T1H);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CYCLES_RESET - 1);
    localparam logic [IDX_W-1:0]  PIX_LAST  = IDX_W'(PIXELS - 1);

    if (!(CYCLES_T0H > 0 && CYCLES_T0H < CYCLES_T1H &&
          CYCLES_T1H < CYCLES_BIT && CYCLES_RESET >= 1)) begin : g_bad_timing
        $error("anton_neopixel_stream: illegal bit timing parameters");
    end
    if (PIXELS < 1 || PIXELS > 256 || (2 ** ADDR_W) < PIXELS) begin : g_bad_size
        $error("anton_neopixel_stream: illegal PIXELS/ADDR_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_RST  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [23:0]       r_mem [0:PIXELS-1];
    logic [23:0]       r_shift;
    logic [TICK_W-1:0] r_tick;
    logic [4:0]        r_bit;
    logic [IDX_W-1:0]  r_pix;
    logic [GAP_W-1:0]  r_gap;
    logic              r_neo;

    logic              w_wr_ok;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_pix_nxt;
    logic              w_tick_end;
    logic              w_bit_end;
    logic              w_frame_end;
    logic              w_gap_end;
    logic              w_load0;
    logic [TICK_W-1:0] w_thr;

    assign w_wr_ok     = {1'b0, WR_ADDR} < (ADDR_W + 1)'(PIXELS);
    assign w_wr_idx    = WR_ADDR[IDX_W-1:0];
    assign w_pix_nxt   = r_pix + 1'b1;
    assign w_tick_end  = (r_tick == TICK_LAST);
    assign w_bit_end   = w_tick_end && (r_bit == 5'd0);
    assign w_frame_end = w_bit_end && (r_pix == PIX_LAST);
    assign w_gap_end   = (r_gap == GAP_LAST);
    assign w_thr       = r_shift[23] ? T1H : T0H;

    always_ff @(posedge CLK_10MHZ) begin
        if (WR_EN && w_wr_ok) begin
            r_mem[w_wr_idx] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load0 = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next  = S_TX;
                    w_load0 = 1'b1;
                end
            end
            S_TX: begin
                if (w_frame_end) begin
                    w_next = S_RST;
                end
            end
            S_RST: begin
                if (w_gap_end) begin
                    w_next  = LOOP ? S_TX : S_IDLE;
                    w_load0 = LOOP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Each pixel is fetched from the buffer only as its first bit begins.
    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_shift <= '0;
            r_tick  <= '0;
            r_bit   <= '0;
            r_pix   <= '0;
        end else if (w_load0) begin
            r_shift <= r_mem[0];
            r_tick  <= '0;
            r_bit   <= 5'd23;
            r_pix   <= '0;
        end else if (r_state == S_TX) begin
            if (!w_tick_end) begin
                r_tick <= r_tick + 1'b1;
            end else begin
                r_tick <= '0;
                if (r_bit != 5'd0) begin
                    r_bit   <= r_bit - 1'b1;
                    r_shift <= {r_shift[22:0], 1'b0};
                end else if (!w_frame_end) begin
                    r_bit   <= 5'd23;
                    r_pix   <= w_pix_nxt;
                    r_shift <= r_mem[w_pix_nxt];
                end
            end
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gap <= '0;
            r_neo <= 1'b0;
        end else begin
            r_neo <= (r_state == S_TX) && (r_tick < w_thr);
            if (r_state == S_RST && !w_gap_end) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
        end
    end

    assign NEO_DATA = r_neo;
    assign BUSY     = (r_state != S_IDLE);
    assign DONE     = (r_state == S_RST) && w_gap_end;
    assign STATE    = r_state;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Scoreboard bench: expected bit high-widths are queued by stimulus and
// checked by a monitor decoding NEO_DATA pulses; frame timing checked inline.
`timescale 1ns/1ps
module tb_anton_neopixel_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start;
    logic        loop_i;
    logic        busy;
    logic        done;
    logic        neo;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int hi = 0;

    anton_neopixel_stream #(
        .PIXELS(2)
    ) dut (
        .CLK_10MHZ(clk),
        .RESET_N  (rst_n),
        .WR_EN    (wr_en),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .START    (start),
        .LOOP     (loop_i),
        .BUSY     (busy),
        .DONE     (done),
        .NEO_DATA (neo),
        .STATE    (state)
    );

    always #50 clk = ~clk;

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hi = 0;
        end else if (neo) begin
            hi++;
        end else if (hi != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", hi, 0);
            end else begin
                chk("bit_high", hi, exp_q.pop_front());
            end
            hi = 0;
        end
    end

    task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1);
        for (int b = 23; b >= 0; b--) exp_q.push_back(p0[b] ? 8 : 3);
        for (int b = 23; b >= 0; b--) exp_q.push_back(p1[b] ? 8 : 3);
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_tx", state, 1);
    endtask

    task automatic run_frame(input int wr_at, input logic [2:0] wa,
                             input logic [23:0] wd, input int start_at,
                             input logic loop_nxt, input logic exp_loop);
        int n, m, d, lowbad, dl;
        n = 0;
        while (state == 2'd1 && n < 2000) begin
            wr_en = (n == wr_at);
            wr_addr = wa; wr_data = wd;
            start = (n == start_at);
            if (n == 10) loop_i = loop_nxt;
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0;
        chk("tx_len", n, 576);
        m = 0; d = 0; lowbad = 0; dl = 0;
        while (state == 2'd2 && m < 2000) begin
            if (done) d++;
            if (neo) lowbad++;
            dl = done;
            start = (m == 100);
            m++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("gap_len", m, 500);
        chk("done_cnt", d, 1);
        chk("done_last", dl, 1);
        chk("gap_low", lowbad, 0);
        chk("after_state", state, exp_loop ? 1 : 0);
        chk("after_busy", busy, exp_loop ? 1 : 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b1; loop_i = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (10) begin
            @(negedge clk);
            chk("rst_neo", neo, 0);
            chk("rst_busy", busy, 0);
            chk("rst_state", state, 0);
            chk("rst_done", done, 0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_state", state, 0);

        wr(3'd0, 24'hff00d5);
        wr(3'd1, 24'h000001);
        push_frame(24'hff00d5, 24'h000001);
        pulse_start();
        run_frame(-1, 3'd0, 24'h0, -1, 1'b0, 1'b0);
        chk("neo_idle", neo, 0);
        chk("q_single", exp_q.size(), 0);

        push_frame(24'hff00d5, 24'h000001);
        push_frame(24'h000000, 24'h000001);
        loop_i = 1'b1;
        pulse_start();
        run_frame(100, 3'd0, 24'h000000, -1, 1'b1, 1'b1);
        run_frame(-1, 3'd0, 24'h0, -1, 1'b0, 1'b0);
        chk("q_loop", exp_q.size(), 0);
        wr(3'd0, 24'hff00d5);

        push_frame(24'hff00d5, 24'h000001);
        pulse_start();
        run_frame(50, 3'd3, 24'h000000, 200, 1'b0, 1'b0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (state != 2'd0) bad++;
        end
        chk("no_restart", bad, 0);
        chk("q_ignore", exp_q.size(), 0);

        push_frame(24'hff00d5, 24'h000001);
        pulse_start();
        repeat (161) @(negedge clk);
        chk("mid_state", state, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_neo", neo, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", state, 0);
        push_frame(24'hff00d5, 24'h000001);
        pulse_start();
        run_frame(-1, 3'd0, 24'h0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("q_replay", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
